// File: rtl/tdm_pkg.sv
`default_nettype none
// tdm_pkg: shared FSM state type and default sizing for the TDM demultiplexer.
// Rev 1.0
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int NCH_DEF    = 4;
  localparam int W_DEF      = 2;
  localparam int MISS_LIMIT = 2;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// tdm_slot_ctr: frame slot counter with explicit wrap at NCH-1, load-to-1 and clear.
// Rev 1.0
module tdm_slot_ctr #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot
);

  logic [SW-1:0] r_slot;

  // Wrap is compared against NCH-1 so non-power-of-2 frame sizes work.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_slot <= '0;
    end else if (load1) begin
      r_slot <= SW'(1);
    end else if (inc) begin
      r_slot <= (r_slot == SW'(NCH - 1)) ? '0 : r_slot + 1'b1;
    end
  end

  assign slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// tdm_demux: serial TDM stream to NCH parallel lanes, with HUNT/LOCK frame alignment.
// Rev 1.0
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_sync,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  localparam int SW = $clog2(NCH);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MW-1:0]   r_miss;
  logic [MW-1:0]   w_miss_nxt;
  logic [MW-1:0]   w_miss_inc;
  logic [SW-1:0]   w_slot;
  logic [SW-1:0]   w_lane;
  logic            w_wr;
  logic            w_lane0;
  logic            w_err;
  logic            w_inc;
  logic            w_load1;
  logic            w_clr;
  logic [W-1:0]    r_lane [NCH];
  logic [NCH-1:0]  r_out_valid;
  logic            r_frame_done;
  logic            r_sync_err;

  tdm_slot_ctr #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .load1 (w_load1),
    .clr   (w_clr),
    .slot  (w_slot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  assign w_miss_inc = r_miss + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_wr        = 1'b0;
    w_lane0     = 1'b0;
    w_err       = 1'b0;
    w_inc       = 1'b0;
    w_load1     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      HUNT: begin
        if (in_valid && in_sync) begin
          w_state_nxt = LOCK;
          w_wr        = 1'b1;
          w_lane0     = 1'b1;
          w_load1     = 1'b1;
          w_miss_nxt  = '0;
        end
      end
      LOCK: begin
        if (in_valid) begin
          w_wr = 1'b1;
          if (in_sync && (w_slot != '0)) begin
            // Early sync: realign so this sample starts a new frame.
            w_err      = 1'b1;
            w_lane0    = 1'b1;
            w_load1    = 1'b1;
            w_miss_nxt = '0;
          end else if (in_sync) begin
            w_inc      = 1'b1;
            w_miss_nxt = '0;
          end else if (w_slot == '0) begin
            w_err = 1'b1;
            if (w_miss_inc >= MW'(MISS_LIMIT)) begin
              w_state_nxt = HUNT;
              w_clr       = 1'b1;
              w_miss_nxt  = '0;
            end else begin
              w_inc      = 1'b1;
              w_miss_nxt = w_miss_inc;
            end
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  assign w_lane = w_lane0 ? '0 : w_slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_lane[k] <= '0;
      end
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_lane[w_lane] <= in_data;
      end
      r_out_valid  <= w_wr ? (NCH'(1) << w_lane) : '0;
      r_frame_done <= w_wr && (w_lane == SW'(NCH - 1));
      r_sync_err   <= w_err;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign out_data[k*W +: W] = r_lane[k];
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = (r_state == LOCK);

endmodule
`default_nettype wire

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of output channels (2..16).
REQ-002 SHALL have parameter W, default 2, meaning sample width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a sample this cycle.
REQ-006 SHALL have port in_data, input, W bits: serial TDM sample.
REQ-007 SHALL have port in_sync, input, 1 bit: qualified by in_valid; marks slot 0 of a frame.
REQ-008 SHALL have port out_data, output, NCH*W bits: lane k at bits [k*W +: W], registered.
REQ-009 SHALL have port out_valid, output, NCH bits: bit k pulses one cycle when lane k updates.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when slot NCH-1 is written.
REQ-011 SHALL have port locked, output, 1 bit: high while in LOCK state.
REQ-012 SHALL have port sync_err, output, 1 bit: one-cycle pulse on any sync violation.

Function
REQ-013 SHALL implement states HUNT and LOCK; no backpressure, so every in_valid sample is consumed.
REQ-014 In HUNT, samples without in_sync SHALL be discarded, with no out_valid and no lane change.
REQ-015 In HUNT, in_valid&in_sync SHALL move to LOCK, write the sample to lane 0 and set slot=1.
REQ-016 In LOCK, each in_valid sample SHALL be written to lane slot, and slot SHALL increment, wrapping from NCH-1 to 0.
REQ-017 Write latency SHALL be 1 cycle: out_data lane k and out_valid[k] SHALL update on the edge after the accepting cycle.
REQ-018 Only the addressed lane SHALL change, and all other lanes SHALL hold their value.
REQ-019 At most one out_valid bit SHALL be high per cycle.
REQ-020 frame_done SHALL assert in the same cycle as out_valid[NCH-1].
REQ-021 In LOCK, in_sync at slot!=0 SHALL pulse sync_err and realign: the sample goes to lane 0, slot=1, and miss_cnt is cleared.
REQ-022 In LOCK, missing in_sync at slot 0 SHALL pulse sync_err, the sample SHALL still go to lane 0, and miss_cnt SHALL increment.
REQ-023 When miss_cnt reaches 2 (two consecutive frames without sync), the FSM SHALL enter HUNT on that edge.
REQ-024 In the REQ-023 case, the sample is still written, and locked deasserts the next cycle.
REQ-025 Correct in_sync at slot 0 SHALL clear miss_cnt.
REQ-026 in_valid=0 cycles SHALL not advance slot and SHALL not pulse any output.
REQ-027 in_sync with in_valid=0 SHALL be ignored.
REQ-028 The slot counter width SHALL be clog2(NCH).
REQ-029 For non-power-of-2 NCH, wrap SHALL occur explicitly at NCH-1.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force HUNT, slot=0 and miss_cnt=0.
REQ-031 rst_n=0 at a clock edge SHALL clear out_data, out_valid, frame_done, locked and sync_err to 0.
REQ-032 Reset mid-frame SHALL discard partial frame state.
REQ-033 A sample presented in the reset cycle SHALL be dropped.
REQ-034 Reset SHALL have priority over all other inputs.

Structure
REQ-035 Package tdm_pkg SHALL hold the state enum (HUNT, LOCK), the default NCH/W constants and MISS_LIMIT=2.
REQ-036 The slot counter with wrap/load-1 SHALL be sub-module tdm_slot_ctr (inputs: inc, load1, clr; output: slot).
REQ-037 Lane registers and the FSM SHALL reside in tdm_demux.

Verification
REQ-038 Reset then 8 samples 1,2,3,0,2,1,3,0 with in_sync on samples 1 and 5 (NCH=4, W=2) -> lanes={1,2,3,0} then {2,1,3,0}, out_valid 0001,0010,0100,1000 repeating, frame_done on samples 4 and 8, sync_err never.
REQ-039 Samples before first in_sync -> no out_valid, out_data stays 0, locked=0 until the cycle after sync.
REQ-040 Locked; in_sync arrives at slot 2 -> sync_err pulse, sample lands in lane 0, next sample lands in lane 1.
REQ-041 Locked; two consecutive frames without in_sync at slot 0 -> sync_err twice, locked drops after the 2nd, later samples are discarded until the next sync.
REQ-042 in_valid toggling 1,0,0,1 with gaps -> slot advances only on valid cycles, and lanes 0,1 are written one cycle after each valid.
REQ-043 rst_n low at slot 2 -> all outputs 0 next cycle; after release, a sample without sync is ignored, and a sample with sync goes to lane 0.
